// File: rtl/mod5_pkg.sv
// Shared types and mod-5 helpers for the serial divisible-by-5 frame transmitter
// and its matching receive-side checker.
package mod5_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TRAIL
  } state_t;

  typedef logic [2:0] residue_t;

  // Next residue after appending bit b: (2r + b) mod 5; illegal residues collapse to 0.
  function automatic residue_t mod5_next(input residue_t r, input logic b);
    residue_t n;
    case (r)
      3'd0:    n = b ? 3'd1 : 3'd0;
      3'd1:    n = b ? 3'd3 : 3'd2;
      3'd2:    n = b ? 3'd0 : 3'd4;
      3'd3:    n = b ? 3'd2 : 3'd1;
      3'd4:    n = b ? 3'd4 : 3'd3;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // 3-bit trailer t such that (8r + t) mod 5 == 0.
  function automatic logic [2:0] mod5_trailer(input residue_t r);
    logic [2:0] t;
    case (r)
      3'd0:    t = 3'b000;
      3'd1:    t = 3'b010;
      3'd2:    t = 3'b100;
      3'd3:    t = 3'b001;
      3'd4:    t = 3'b011;
      default: t = 3'b000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mod5_residue.sv
// Serial mod-5 residue register: folds one bit per enabled cycle into r.
module mod5_residue
  import mod5_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     en,
  input  logic     b,
  output residue_t r
);

  residue_t r_res;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_res <= '0;
    end else if (en) begin
      r_res <= mod5_next(r_res, b);
    end
  end

  assign r = r_res;

endmodule

// File: rtl/mod5_frame_tx.sv
// Shifts a W-bit word out MSB-first followed by a 3-bit trailer that makes the
// whole (W+3)-bit frame a multiple of 5; all outputs are registered.
module mod5_frame_tx
  import mod5_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic         ready,
  output logic         x,
  output logic         x_valid,
  output logic         last,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 3);

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_shift, w_shift_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [2:0]     r_trail, w_trail_nx;
  logic           r_x, w_x_nx;
  logic           r_valid, w_valid_nx;
  logic           r_last, w_last_nx;
  logic           r_busy, w_busy_nx;
  logic           r_ready, w_ready_nx;
  logic           w_accept, w_clr, w_en;
  residue_t       w_res, w_res_fin;

  assign w_accept = start & r_ready;

  // The residue register trails the output by one bit, so fold the bit on x in now.
  assign w_res_fin = mod5_next(w_res, r_x);

  mod5_residue u_residue (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .b   (r_x),
    .r   (w_res)
  );

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_trail_nx = r_trail;
    w_x_nx     = 1'b0;
    w_valid_nx = 1'b0;
    w_last_nx  = 1'b0;
    w_busy_nx  = 1'b0;
    w_ready_nx = 1'b0;
    w_clr      = 1'b0;
    w_en       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready_nx = 1'b1;
      end
      S_DATA: begin
        w_en       = 1'b1;
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b1;
        if (r_cnt == CW'(W - 1)) begin
          w_state_nx = S_TRAIL;
          w_trail_nx = mod5_trailer(w_res_fin);
          w_x_nx     = w_trail_nx[2];
          w_cnt_nx   = '0;
        end else begin
          w_x_nx     = r_shift[W-1];
          w_shift_nx = {r_shift[W-2:0], 1'b0};
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_TRAIL: begin
        if (r_cnt == CW'(2)) begin
          w_state_nx = S_IDLE;
          w_ready_nx = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_x_nx     = (r_cnt == '0) ? r_trail[1] : r_trail[0];
          w_cnt_nx   = r_cnt + CW'(1);
          if (r_cnt == CW'(1)) begin
            w_last_nx  = 1'b1;
            w_ready_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_ready_nx = 1'b1;
      end
    endcase

    // Acceptance is only possible in IDLE or on trailer bit 0, so it overrides either path.
    if (w_accept) begin
      w_state_nx = S_DATA;
      w_x_nx     = data_in[W-1];
      w_shift_nx = {data_in[W-2:0], 1'b0};
      w_cnt_nx   = '0;
      w_valid_nx = 1'b1;
      w_busy_nx  = 1'b1;
      w_last_nx  = 1'b0;
      w_ready_nx = 1'b0;
      w_clr      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_trail <= '0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_cnt   <= w_cnt_nx;
      r_trail <= w_trail_nx;
      r_x     <= w_x_nx;
      r_valid <= w_valid_nx;
      r_last  <= w_last_nx;
      r_busy  <= w_busy_nx;
      r_ready <= w_ready_nx;
    end
  end

  assign ready   = r_ready;
  assign x       = r_x;
  assign x_valid = r_valid;
  assign last    = r_last;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mod5_frame_tx.sv
// Scoreboard bench for mod5_frame_tx: expected frame bits are queued at acceptance
// and popped by an independent monitor that also checks each frame is divisible by 5.
module tb_mod5_frame_tx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         ready;
  logic         x;
  logic         x_valid;
  logic         last;
  logic         busy;

  typedef struct packed {
    logic x;
    logic last;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          run_len = 0;
  int          last_run = 0;
  logic [15:0] acc = '0;
  int          acc_bits = 0;

  mod5_frame_tx #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .ready   (ready),
    .x       (x),
    .x_valid (x_valid),
    .last    (last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (x_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_bit: got x=%0b last=%0b expected no frame bit at %0t", x, last, $time);
      end else begin
        e = q.pop_front();
        check("frame_bit", {30'd0, x, last}, {30'd0, e.x, e.last});
      end
      acc = {acc[14:0], x};
      acc_bits++;
      run_len++;
      if (last === 1'b1) begin
        check("frame_len", acc_bits, 11);
        check("frame_mod5", {16'd0, acc % 16'd5}, 0);
        acc = '0;
        acc_bits = 0;
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      check("idle_x_last", {30'd0, x, last}, 0);
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] f);
    int unsigned n = 0;
    start = 1'b1;
    data_in = d;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got ready=%0b expected 1 for data %0h", ready, d);
      start = 1'b0;
      return;
    end
    for (int i = 10; i >= 0; i--) q.push_back('{x: f[i], last: (i == 0)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0 || q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected 0/0", busy, q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] t;
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", x_valid, 0);
    check("rst_last", last, 0);
    check("rst_x", x, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero word, with mid-frame status checks
    send(8'h00, 11'b00000000_000);
    @(negedge clk);
    check("data_busy", busy, 1);
    check("data_ready", ready, 0);
    wait_idle();
    check("post_zero_ready", ready, 1);

    // Residues 2, 1, 0, 4
    send(8'h07, 11'b00000111_100); wait_idle();
    send(8'h01, 11'b00000001_010); wait_idle();
    send(8'hFF, 11'b11111111_000); wait_idle();
    send(8'h04, 11'b00000100_011); wait_idle();

    // Back-to-back: one contiguous 22-bit run
    send(8'h07, 11'b00000111_100);
    send(8'h01, 11'b00000001_010);
    wait_idle();
    @(negedge clk); #1;
    check("b2b_run", last_run, 22);

    // Start while busy is ignored
    send(8'h07, 11'b00000111_100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset while data bit 5 is on the line, with a competing start
    send(8'hFF, 11'b11111111_000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b1;
    data_in = 8'h07;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    q.delete();
    acc = '0;
    acc_bits = 0;
    @(negedge clk);
    check("rstmid_valid", x_valid, 0);
    check("rstmid_ready", ready, 1);
    check("rstmid_busy", busy, 0);
    @(posedge clk); #1;
    send(8'h04, 11'b00000100_011);
    wait_idle();

    // Loopback over every word, back-to-back
    for (int d = 0; d < 256; d++) begin
      t = 3'((5 - ((3 * d) % 5)) % 5);
      send(8'(d), {8'(d), t});
    end
    wait_idle();
    check("final_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
